// File: rtl/paddle_ctrl_multi.sv
// N-channel paddle position controller: per-channel IDLE/UP/DOWN FSM with speed ramp, updated on frame ticks.
// Optional PADDLE_AUTO_EN adds auto_mode/target_y tracking with a DEADBAND parameter.

module paddle_ctrl_chan #(
   parameter int Y_W        = 10,
   parameter int Y_MIN      = 30,
   parameter int Y_MAX      = 329,
   parameter int Y_INIT     = 180,
   parameter int DELTA_MIN  = 1,
   parameter int DELTA_MAX  = 8,
   parameter int RAMP_TICKS = 4
`ifdef PADDLE_AUTO_EN
  ,parameter int DEADBAND   = 4
`endif
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           tick,
   input  logic           up,
   input  logic           down,
`ifdef PADDLE_AUTO_EN
   input  logic           auto_mode,
   input  logic [Y_W-1:0] target_y,
`endif
   output logic [Y_W-1:0] y,
   output logic           moving,
   output logic           at_limit
);

   localparam int SPD_W = $clog2(DELTA_MAX + 1);
   localparam int CNT_W = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;

   localparam logic [Y_W-1:0]   YMIN    = Y_W'(Y_MIN);
   localparam logic [Y_W-1:0]   YMAX    = Y_W'(Y_MAX);
   localparam logic [Y_W-1:0]   YINIT   = Y_W'(Y_INIT);
   localparam logic [Y_W:0]     YMIN_X  = (Y_W+1)'(Y_MIN);
   localparam logic [Y_W:0]     YMAX_X  = (Y_W+1)'(Y_MAX);
   localparam logic [SPD_W-1:0] DMIN_S  = SPD_W'(DELTA_MIN);
   localparam logic [SPD_W-1:0] DMAX_S  = SPD_W'(DELTA_MAX);
   localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(RAMP_TICKS - 1);
   localparam logic             INIT_LIM = (Y_INIT == Y_MIN) || (Y_INIT == Y_MAX);

   typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

   state_t           state, state_nx;
   logic [SPD_W-1:0] spd, spd_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [Y_W-1:0]   y_nx;
   logic [Y_W-1:0]   step;
   logic [Y_W:0]     sum, lo_thr;
   logic             req_up, req_dn, no_ramp;

`ifdef PADDLE_AUTO_EN
   localparam logic [Y_W-1:0] HALF = Y_W'(DELTA_MAX / 2);
   localparam logic [Y_W:0]   DB_X = (Y_W+1)'(DEADBAND);
   logic [Y_W-1:0] diff;
`endif

   always_comb begin
      req_up  = up & ~down;
      req_dn  = down & ~up;
      no_ramp = 1'b0;
`ifdef PADDLE_AUTO_EN
      diff = (target_y > y) ? (target_y - y) : (y - target_y);
      if (auto_mode) begin
         req_up  = {1'b0, target_y} > ({1'b0, y} + DB_X);
         req_dn  = ({1'b0, target_y} + DB_X) < {1'b0, y};
         no_ramp = 1'b1;
      end
`endif
   end

   always_comb begin
      state_nx = state;
      spd_nx   = spd;
      cnt_nx   = cnt;
      y_nx     = y;
      step     = Y_W'(spd);
      sum      = '0;
      lo_thr   = '0;
      if (tick) begin
         if (req_up || req_dn) begin
            state_nx = req_up ? UP : DOWN;
            // Entering or reversing restarts the ramp; continuing advances it.
            if ((state != state_nx) || no_ramp) begin
               spd_nx = DMIN_S;
               cnt_nx = '0;
            end else if (cnt == CNT_TOP) begin
               cnt_nx = '0;
               spd_nx = (spd >= DMAX_S) ? DMAX_S : spd + SPD_W'(1);
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
            step = Y_W'(spd_nx);
`ifdef PADDLE_AUTO_EN
            if (auto_mode)
               step = (diff < HALF) ? diff : HALF;
`endif
            sum    = {1'b0, y} + {1'b0, step};
            lo_thr = YMIN_X + {1'b0, step};
            if (req_up)
               y_nx = (sum > YMAX_X) ? YMAX : sum[Y_W-1:0];
            else
               y_nx = ({1'b0, y} < lo_thr) ? YMIN : (y - step);
         end else begin
            state_nx = IDLE;
            spd_nx   = DMIN_S;
            cnt_nx   = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         spd      <= DMIN_S;
         cnt      <= '0;
         y        <= YINIT;
         moving   <= 1'b0;
         at_limit <= INIT_LIM;
      end else begin
         state    <= state_nx;
         spd      <= spd_nx;
         cnt      <= cnt_nx;
         y        <= y_nx;
         moving   <= (state_nx != IDLE);
         at_limit <= (y_nx == YMIN) || (y_nx == YMAX);
      end
   end

endmodule

module paddle_ctrl_multi #(
   parameter int N_PADDLES  = 2,
   parameter int Y_W        = 10,
   parameter int Y_MIN      = 30,
   parameter int Y_MAX      = 329,
   parameter int Y_INIT     = 180,
   parameter int DELTA_MIN  = 1,
   parameter int DELTA_MAX  = 8,
   parameter int RAMP_TICKS = 4
`ifdef PADDLE_AUTO_EN
  ,parameter int DEADBAND   = 4
`endif
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     tick,
   input  logic [N_PADDLES-1:0]     up,
   input  logic [N_PADDLES-1:0]     down,
`ifdef PADDLE_AUTO_EN
   input  logic [N_PADDLES-1:0]     auto_mode,
   input  logic [N_PADDLES*Y_W-1:0] target_y,
`endif
   output logic [N_PADDLES*Y_W-1:0] y,
   output logic [N_PADDLES-1:0]     moving,
   output logic [N_PADDLES-1:0]     at_limit
);

   for (genvar i = 0; i < N_PADDLES; i++) begin : g_chan
      paddle_ctrl_chan #(
         .Y_W(Y_W), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX), .Y_INIT(Y_INIT),
         .DELTA_MIN(DELTA_MIN), .DELTA_MAX(DELTA_MAX), .RAMP_TICKS(RAMP_TICKS)
`ifdef PADDLE_AUTO_EN
        ,.DEADBAND(DEADBAND)
`endif
      ) u_chan (
         .clk      (clk),
         .reset    (reset),
         .tick     (tick),
         .up       (up[i]),
         .down     (down[i]),
`ifdef PADDLE_AUTO_EN
         .auto_mode(auto_mode[i]),
         .target_y (target_y[i*Y_W +: Y_W]),
`endif
         .y        (y[i*Y_W +: Y_W]),
         .moving   (moving[i]),
         .at_limit (at_limit[i])
      );
   end

endmodule

// File: tb/tb_paddle_ctrl_multi.sv
// Scoreboard bench for paddle_ctrl_multi: driver pushes reference-model expectations, monitor pops and compares.
module tb_paddle_ctrl_multi;
   localparam int N = 2, YW = 10, YMIN = 30, YMAX = 329, YINIT = 180;
   localparam int DMIN = 1, DMAX = 8, RAMP = 4;

   logic clk = 0, reset = 1, tick = 0;
   logic [N-1:0] up = '0, down = '0;
   logic [N*YW-1:0] y;
   logic [N-1:0] moving, at_limit;

   paddle_ctrl_multi #(.N_PADDLES(N), .Y_W(YW), .Y_MIN(YMIN), .Y_MAX(YMAX), .Y_INIT(YINIT),
                       .DELTA_MIN(DMIN), .DELTA_MAX(DMAX), .RAMP_TICKS(RAMP)) dut (
      .clk(clk), .reset(reset), .tick(tick), .up(up), .down(down),
      .y(y), .moving(moving), .at_limit(at_limit));

   always #5 clk = ~clk;

   typedef struct {int y[N]; logic mv[N]; logic lim[N];} exp_t;
   exp_t q[$];
   int checks = 0, failures = 0;

   // Reference state: position, requested direction, and how many consecutive ticks it has been held.
   int my[N], mdir[N], mheld[N];

   function automatic void chk(string name, int act, int expv);
      checks++;
      if (act != expv) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
      end
   endfunction

   function automatic int yof(int c);
      return int'(y[c*YW +: YW]);
   endfunction

   task automatic model_step(input logic r, input logic t, input logic [N-1:0] u, input logic [N-1:0] d);
      exp_t e;
      for (int c = 0; c < N; c++) begin
         if (r) begin
            my[c] = YINIT; mdir[c] = 0; mheld[c] = 0;
         end else if (t) begin
            int req, sp;
            req = (u[c] && !d[c]) ? 1 : (d[c] && !u[c]) ? -1 : 0;
            if (req == 0) begin
               mdir[c] = 0; mheld[c] = 0;
            end else begin
               if (req == mdir[c]) mheld[c]++;
               else begin mheld[c] = 1; mdir[c] = req; end
               sp = DMIN + (mheld[c] - 1) / RAMP;
               if (sp > DMAX) sp = DMAX;
               if (req > 0) my[c] = (my[c] + sp > YMAX) ? YMAX : my[c] + sp;
               else         my[c] = (my[c] - sp < YMIN) ? YMIN : my[c] - sp;
            end
         end
         e.y[c]   = my[c];
         e.mv[c]  = (mdir[c] != 0);
         e.lim[c] = (my[c] == YMIN) || (my[c] == YMAX);
      end
      q.push_back(e);
   endtask

   task automatic cyc(input logic r, input logic t, input logic [N-1:0] u, input logic [N-1:0] d);
      @(negedge clk);
      reset = r; tick = t; up = u; down = d;
      model_step(r, t, u, d);
   endtask

   // Wait until the outputs for the last driven cycle are visible.
   task automatic settle();
      @(posedge clk); #2;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk); #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            for (int c = 0; c < N; c++) begin
               chk($sformatf("y[%0d]", c), yof(c), e.y[c]);
               chk($sformatf("moving[%0d]", c), int'(moving[c]), int'(e.mv[c]));
               chk($sformatf("at_limit[%0d]", c), int'(at_limit[c]), int'(e.lim[c]));
            end
         end
      end
   end

   initial begin : driver
      logic [N-1:0] ru, rd;
      int budget;
      for (int i = 0; i < 3; i++) cyc(1, 0, '0, '0);
      for (int i = 0; i < 10; i++) cyc(0, 1, '0, '0);
      settle();
      chk("idle_y0", yof(0), 180); chk("idle_y1", yof(1), 180);
      chk("idle_moving", int'(moving), 0);

      for (int i = 0; i < 9; i++) cyc(0, 1, 2'b01, 2'b00);
      settle();
      chk("ramp9_y0", yof(0), 195); chk("ramp9_y1", yof(1), 180);

      for (int i = 0; i < 30; i++) cyc(0, 1, 2'b01, 2'b00);
      settle();
      chk("top_y0", yof(0), 329); chk("top_limit0", int'(at_limit[0]), 1);
      cyc(0, 1, 2'b00, 2'b01); settle();
      chk("reverse_y0", yof(0), 328);
      cyc(0, 1, 2'b00, 2'b01); settle();
      chk("reverse2_y0", yof(0), 327);

      for (int i = 0; i < 5; i++) cyc(0, 1, 2'b10, 2'b10);
      settle();
      chk("both_y1", yof(1), 180); chk("both_moving1", int'(moving[1]), 0);
      for (int i = 0; i < 100; i++) cyc(0, 0, 2'($urandom), 2'($urandom));
      settle();
      chk("notick_y1", yof(1), 180);

      cyc(0, 1, '0, '0);
      for (int i = 0; i < 17; i++) cyc(0, 1, 2'b01, 2'b00);
      cyc(1, 1, 2'b01, 2'b00); settle();
      chk("reset_tick_y0", yof(0), 180);
      cyc(0, 1, 2'b01, 2'b00); settle();
      chk("post_reset_step_y0", yof(0), 181);

      // Random section: sticky buttons so ramps build up, sparse resets.
      ru = '0; rd = '0;
      for (int i = 0; i < 1500; i++) begin
         for (int c = 0; c < N; c++) begin
            if ($urandom_range(7) == 0) ru[c] = $urandom_range(1);
            if ($urandom_range(7) == 0) rd[c] = $urandom_range(1);
         end
         cyc(logic'($urandom_range(199) == 0), logic'($urandom_range(2) != 0), ru, rd);
      end
      cyc(0, 0, '0, '0);

      budget = 0;
      while (q.size() > 0 && budget < 20) begin @(negedge clk); budget++; end
      chk("scoreboard_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
